// File: rtl/dm_resp_pkg.sv
// Shared types and defaults for the CPU data-memory responder.
package dm_resp_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        WAIT = 2'd2,
        DONE = 2'd3
    } dm_state_e;

    localparam logic [3:0]  WEB_NONE       = 4'hF;
    localparam int unsigned DM_TIMEOUT_DEF = 255;
    localparam int unsigned CNT_W          = 8;

endpackage

// File: rtl/dm_responder.sv
// CPU data-memory port to valid/ready bus: one bus transaction per CPU request, best case 3 stall cycles.
// Request held stable until req_ready; DONE is held while ext_stall so the unchanged request is not reissued.
module dm_responder
    import dm_resp_pkg::*;
#(
    parameter int ADDR_W  = 32,
    parameter int DATA_W  = 32,
    parameter int TIMEOUT = DM_TIMEOUT_DEF
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [ADDR_W-1:0] DM_A,
    input  logic [DATA_W-1:0] DM_DI,
    input  logic [3:0]        DM_WEB,
    input  logic              DM_OE,
    input  logic              ext_stall,
    output logic [DATA_W-1:0] DM_DO,
    output logic              dm_stall,
    output logic              req_valid,
    input  logic              req_ready,
    output logic              req_write,
    output logic [ADDR_W-1:0] req_addr,
    output logic [DATA_W-1:0] req_wdata,
    output logic [3:0]        req_wstrb,
    input  logic              rsp_valid,
    input  logic [DATA_W-1:0] rsp_rdata,
    input  logic              rsp_err,
    output logic              bus_err
);

    dm_state_e         r_state;
    dm_state_e         w_state_nxt;
    logic [ADDR_W-1:0] r_addr;
    logic [DATA_W-1:0] r_wdata;
    logic [3:0]        r_wstrb;
    logic              r_write;
    logic [DATA_W-1:0] r_rdata;
    logic              r_err;
    logic [CNT_W-1:0]  r_cnt;

    logic              w_is_write;
    logic              w_req_present;
    logic              w_capture;
    logic              w_load;
    logic [DATA_W-1:0] w_load_data;
    logic              w_set_err;
    logic              w_cnt_last;

    assign w_is_write    = (DM_WEB != WEB_NONE);
    assign w_req_present = DM_OE | w_is_write;
    // Last WAIT cycle: the counter would reach TIMEOUT on this edge.
    assign w_cnt_last    = (r_cnt == CNT_W'(TIMEOUT - 1));

    always_comb begin
        w_state_nxt = r_state;
        w_capture   = 1'b0;
        w_load      = 1'b0;
        w_load_data = '0;
        w_set_err   = 1'b0;
        case (r_state)
            IDLE: begin
                if (w_req_present) begin
                    w_capture   = 1'b1;
                    w_state_nxt = REQ;
                end
            end
            REQ: begin
                if (req_ready) begin
                    w_state_nxt = WAIT;
                end
            end
            WAIT: begin
                if (rsp_valid) begin
                    w_state_nxt = DONE;
                    w_load      = 1'b1;
                    w_load_data = r_write ? '0 : rsp_rdata;
                    w_set_err   = rsp_err;
                end else if (w_cnt_last) begin
                    w_state_nxt = DONE;
                    w_load      = 1'b1;
                    w_set_err   = 1'b1;
                end
            end
            DONE: begin
                if (!ext_stall) begin
                    w_state_nxt = IDLE;
                end
            end
            default: w_state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Write wins over a simultaneous read request.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_addr  <= '0;
            r_wdata <= '0;
            r_wstrb <= '0;
            r_write <= 1'b0;
        end else if (w_capture) begin
            r_addr  <= DM_A;
            r_wdata <= DM_DI;
            r_wstrb <= ~DM_WEB;
            r_write <= w_is_write;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_cnt <= '0;
        end else if (r_state == REQ && req_ready) begin
            r_cnt <= '0;
        end else if (r_state == WAIT) begin
            r_cnt <= r_cnt + 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_rdata <= '0;
            r_err   <= 1'b0;
        end else begin
            if (w_load) begin
                r_rdata <= w_load_data;
            end
            if (w_set_err) begin
                r_err <= 1'b1;
            end
        end
    end

    assign dm_stall  = ((r_state == IDLE) && w_req_present) || (r_state == REQ) || (r_state == WAIT);
    assign req_valid = (r_state == REQ);
    assign req_write = r_write;
    assign req_addr  = r_addr;
    assign req_wdata = r_wdata;
    assign req_wstrb = r_wstrb;
    assign DM_DO     = r_rdata;
    assign bus_err   = r_err;

endmodule

// File: tb/tb_dm_responder.sv
// Directed and randomized checks of dm_responder against a transaction-level model.
module tb_dm_responder;

    localparam int TO = 4;

    logic        clk;
    logic        rst;
    logic [31:0] DM_A;
    logic [31:0] DM_DI;
    logic [3:0]  DM_WEB;
    logic        DM_OE;
    logic        ext_stall;
    logic [31:0] DM_DO;
    logic        dm_stall;
    logic        req_valid;
    logic        req_ready;
    logic        req_write;
    logic [31:0] req_addr;
    logic [31:0] req_wdata;
    logic [3:0]  req_wstrb;
    logic        rsp_valid;
    logic [31:0] rsp_rdata;
    logic        rsp_err;
    logic        bus_err;

    int          checks;
    int          errors;
    logic        model_err;
    logic [31:0] prev_do;

    dm_responder #(
        .ADDR_W (32),
        .DATA_W (32),
        .TIMEOUT(TO)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .DM_A     (DM_A),
        .DM_DI    (DM_DI),
        .DM_WEB   (DM_WEB),
        .DM_OE    (DM_OE),
        .ext_stall(ext_stall),
        .DM_DO    (DM_DO),
        .dm_stall (dm_stall),
        .req_valid(req_valid),
        .req_ready(req_ready),
        .req_write(req_write),
        .req_addr (req_addr),
        .req_wdata(req_wdata),
        .req_wstrb(req_wstrb),
        .rsp_valid(rsp_valid),
        .rsp_rdata(rsp_rdata),
        .rsp_err  (rsp_err),
        .bus_err  (bus_err)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, errors=%0d", errors);
        $fatal(1, "watchdog expired");
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst       = 1'b0;
        DM_OE     = 1'b0;
        DM_WEB    = 4'hF;
        ext_stall = 1'b0;
        req_ready = 1'b0;
        rsp_valid = 1'b0;
        rsp_err   = 1'b0;
        #1;
        chk("rst_req_valid", req_valid, 1'b0);
        chk("rst_req_write", req_write, 1'b0);
        chk("rst_req_addr",  req_addr,  32'h0);
        chk("rst_req_wdata", req_wdata, 32'h0);
        chk("rst_req_wstrb", req_wstrb, 4'h0);
        chk("rst_dm_do",     DM_DO,     32'h0);
        chk("rst_bus_err",   bus_err,   1'b0);
        chk("rst_dm_stall",  dm_stall,  1'b0);
        @(posedge clk);
        @(posedge clk);
        #1;
        rst       = 1'b1;
        model_err = 1'b0;
        prev_do   = 32'h0;
        cyc();
    endtask

    // Entered and left at posedge+1 with the DUT in IDLE.
    task automatic idle_check();
        DM_OE     = 1'b0;
        DM_WEB    = 4'hF;
        rsp_valid = 1'b0;
        rsp_err   = 1'b0;
        #1;
        chk("idle_dm_stall",  dm_stall,  1'b0);
        chk("idle_req_valid", req_valid, 1'b0);
        chk("idle_dm_do",     DM_DO,     prev_do);
        cyc();
    endtask

    // One CPU request: bus accepts after rdy_dly refused REQ cycles and responds
    // after rsp_dly silent WAIT cycles; ext_stall holds DONE for hold extra cycles.
    task automatic run_txn(input logic [31:0] a, input logic [31:0] di, input logic [3:0] web,
                           input logic oe, input int rdy_dly, input int rsp_dly,
                           input logic [31:0] rdata, input logic err, input int hold,
                           input logic spur);
        logic        wr;
        logic        timed_out;
        logic [31:0] exp_do;
        logic [3:0]  exp_strb;
        logic        exp_err;
        int          exp_stall;
        int          nreq;
        int          nwait;
        int          stall_cnt;
        int          hs;
        logic        in_wait;
        logic        done_seen;

        wr        = (web != 4'hF);
        exp_strb  = ~web;
        timed_out = (rsp_dly >= TO);
        exp_do    = (timed_out || wr) ? 32'h0 : rdata;
        exp_err   = model_err | (timed_out ? 1'b1 : err);
        exp_stall = 1 + (rdy_dly + 1) + (timed_out ? TO : rsp_dly + 1);

        DM_A      = a;
        DM_DI     = di;
        DM_WEB    = web;
        DM_OE     = oe;
        ext_stall = 1'b0;
        nreq      = 0;
        nwait     = 0;
        stall_cnt = 0;
        hs        = 0;
        in_wait   = 1'b0;
        done_seen = 1'b0;

        for (int c = 0; c < 400 && !done_seen; c++) begin
            if (c > 0) cyc();
            req_ready = req_valid && (nreq == rdy_dly);
            if (in_wait && nwait == rsp_dly) begin
                rsp_valid = 1'b1;
                rsp_rdata = rdata;
                rsp_err   = err;
            end else begin
                rsp_valid = spur && !in_wait;
                rsp_rdata = $urandom;
                rsp_err   = spur && !in_wait;
            end
            #1;
            if (c == 0) chk("stall_on_request", dm_stall, 1'b1);
            if (dm_stall) begin
                stall_cnt++;
                chk("do_stable_in_stall", DM_DO, prev_do);
                if (req_valid) begin
                    chk("req_addr",  req_addr,  a);
                    chk("req_write", req_write, wr);
                    chk("req_wstrb", req_wstrb, exp_strb);
                    chk("req_wdata", req_wdata, di);
                    if (req_ready) begin
                        hs++;
                        in_wait = 1'b1;
                        nwait   = 0;
                    end else begin
                        nreq++;
                    end
                end else if (in_wait) begin
                    if (rsp_valid) in_wait = 1'b0;
                    else nwait++;
                end
            end else if (c > 0) begin
                done_seen = 1'b1;
            end
        end

        chk("txn_completed", done_seen, 1'b1);
        chk("done_dm_do",    DM_DO,     exp_do);
        chk("done_bus_err",  bus_err,   exp_err);
        chk("stall_cycles",  stall_cnt, exp_stall);
        chk("handshakes",    hs,        32'd1);
        model_err = exp_err;
        prev_do   = exp_do;

        req_ready = 1'b0;
        ext_stall = (hold != 0);
        for (int h = 0; h < hold; h++) begin
            cyc();
            if (h == hold - 1) ext_stall = 1'b0;
            #1;
            chk("hold_dm_stall",  dm_stall,  1'b0);
            chk("hold_req_valid", req_valid, 1'b0);
            chk("hold_dm_do",     DM_DO,     prev_do);
        end
        cyc();
        rsp_valid = 1'b0;
        rsp_err   = 1'b0;
    endtask

    initial begin
        checks    = 0;
        errors    = 0;
        model_err = 1'b0;
        prev_do   = 32'h0;
        rst       = 1'b1;
        DM_A      = 32'h0;
        DM_DI     = 32'h0;
        DM_WEB    = 4'hF;
        DM_OE     = 1'b0;
        ext_stall = 1'b0;
        req_ready = 1'b0;
        rsp_valid = 1'b0;
        rsp_rdata = 32'h0;
        rsp_err   = 1'b0;
        #2;
        do_reset();

        // Load on a fast bus: three stall cycles
        run_txn(32'h0001_0004, 32'h0, 4'hF, 1'b1, 0, 0, 32'hCAFE_F00D, 1'b0, 0, 1'b0);
        idle_check();
        // Byte store with three refused REQ cycles
        run_txn(32'h0000_0020, 32'h0000_00AB, 4'b1110, 1'b0, 3, 1, 32'hDEAD_BEEF, 1'b0, 0, 1'b1);
        idle_check();
        // ext_stall keeps DONE
        run_txn(32'h0000_0040, 32'h0, 4'hF, 1'b1, 1, 2, 32'h1234_5678, 1'b0, 4, 1'b1);
        idle_check();
        // Back-to-back identical loads
        run_txn(32'h0000_0100, 32'h0, 4'hF, 1'b1, 0, 0, 32'h1111_1111, 1'b0, 0, 1'b0);
        run_txn(32'h0000_0100, 32'h0, 4'hF, 1'b1, 0, 1, 32'h2222_2222, 1'b0, 0, 1'b0);
        idle_check();
        // Error response still returns data and sets the sticky flag
        run_txn(32'h0000_0200, 32'h0, 4'hF, 1'b1, 0, 0, 32'h3333_3333, 1'b1, 0, 1'b0);
        idle_check();
        do_reset();

        for (int n = 0; n < 30; n++) begin
            logic [3:0] web;
            logic       oe;
            if ($urandom_range(0, 2) == 0) begin
                web = 4'hF;
                oe  = 1'b1;
            end else begin
                web = 4'($urandom_range(0, 14));
                oe  = 1'($urandom_range(0, 1));
            end
            run_txn($urandom, $urandom, web, oe, $urandom_range(0, 3), $urandom_range(0, 5),
                    $urandom, ($urandom_range(0, 7) == 0), $urandom_range(0, 2),
                    1'($urandom_range(0, 1)));
            if ($urandom_range(0, 1) == 1) idle_check();
        end
        idle_check();
        do_reset();

        // Timeout, then bus_err stays set on a clean transaction
        run_txn(32'h0000_0300, 32'h0, 4'hF, 1'b1, 0, 10, 32'h4444_4444, 1'b0, 1, 1'b0);
        idle_check();
        run_txn(32'h0000_0304, 32'h0, 4'hF, 1'b1, 0, 0, 32'h5555_5555, 1'b0, 0, 1'b0);
        idle_check();

        // Reset while in WAIT; the late response must be ignored
        DM_A   = 32'h0000_0400;
        DM_OE  = 1'b1;
        DM_WEB = 4'hF;
        #1;
        chk("rw_stall_idle", dm_stall, 1'b1);
        cyc();
        req_ready = 1'b1;
        #1;
        chk("rw_req_valid", req_valid, 1'b1);
        cyc();
        req_ready = 1'b0;
        #1;
        chk("rw_stall_wait", dm_stall, 1'b1);
        rst   = 1'b0;
        DM_OE = 1'b0;
        #1;
        chk("rw_rst_req_valid", req_valid, 1'b0);
        chk("rw_rst_req_addr",  req_addr,  32'h0);
        chk("rw_rst_bus_err",   bus_err,   1'b0);
        chk("rw_rst_dm_do",     DM_DO,     32'h0);
        chk("rw_rst_stall",     dm_stall,  1'b0);
        cyc();
        rst       = 1'b1;
        rsp_valid = 1'b1;
        rsp_rdata = 32'h5555_AAAA;
        rsp_err   = 1'b1;
        #1;
        chk("rw_post_stall", dm_stall, 1'b0);
        cyc();
        rsp_valid = 1'b0;
        rsp_err   = 1'b0;
        #1;
        chk("rw_post_req_valid", req_valid, 1'b0);
        chk("rw_post_dm_do",     DM_DO,     32'h0);
        chk("rw_post_bus_err",   bus_err,   1'b0);
        chk("rw_post_stall2",    dm_stall,  1'b0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
